ifu_pfb: RTL
============

Name: ifu_pfb

Overview:
- Next-generation instruction fetch unit with a parametrised prefetch buffer.
- Issues word fetches to the single-cycle-latency ITCM and queues {pc, ir} pairs in a DEPTH-entry FIFO.
- Presents the FIFO head to EXU over a valid/ready handshake.
- Handles branch/jump flush and trap redirect (to mtvec); captures the trap EPC.
- Sits between the ITCM and the EXU, replacing the unbuffered fetch path.

Parameters:
- PC_W, 32, fetch address width.
- XLEN, 32, instruction word width.
- DEPTH, 4, prefetch FIFO entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] = 0.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- itcm_o_en  out  1  ITCM read enable.
- itcm_o_addr  out  PC_W  ITCM read address (word aligned).
- itcm_i_rdata  in  XLEN  ITCM read data, valid the cycle after itcm_o_en.
- ifu_o_valid  out  1  FIFO head valid.
- ifu_i_ready  in  1  EXU accepts head.
- ifu_o_ir  out  XLEN  head instruction.
- ifu_o_pc  out  PC_W  head pc.
- ifu_i_flush_req  in  1  bjp redirect request.
- ifu_i_flush_pc  in  PC_W  bjp target.
- ifu_i_trap_req  in  1  irq/exception redirect request.
- ifu_i_mtvec  in  PC_W  trap vector.
- ifu_o_wbck_epc  out  PC_W  captured trap EPC.
- ifu_o_fifo_cnt  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values:
  - fpc (fetch pc) = RESET_PC.
  - FIFO empty; ifu_o_fifo_cnt = 0; ifu_o_valid = 0.
  - in-flight flag = 0; itcm_o_en = 0.
  - ifu_o_wbck_epc = 0.
  - ifu_o_ir and ifu_o_pc = 0 while empty.
- Issue:
  - Condition: itcm_o_en = 1 when no redirect this cycle and (fifo_cnt + inflight - pop) < DEPTH, where pop = ifu_o_valid & ifu_i_ready.
  - itcm_o_addr = fpc. On issue, fpc <= fpc + 4, wrapping mod 2^PC_W.
  - First issue is the cycle after rst_n deasserts.
- In-flight:
  - Issue sets inflight and latches the issued pc.
  - Next cycle, {inflight_pc, itcm_i_rdata} is pushed into the FIFO, unless killed by a redirect.
- Latency and throughput:
  - Issue in cycle k gives ifu_o_valid in cycle k+2. There is no bypass; the head is always read from a register.
  - Sustained throughput is 1 instruction/cycle with ifu_i_ready held high.
- Handshake:
  - ifu_o_valid = FIFO non-empty; it is not masked by redirect.
  - Transfer occurs when valid & ready; the head is popped at that edge.
  - Head data is stable while valid & !ready.
  - Order is strictly FIFO; no drop, no duplication.
- Full/empty:
  - Push and pop in the same cycle leaves the count unchanged.
  - Push while full cannot occur, because the credit rule prevents it.
  - Pop while empty is ignored.
  - Read and write pointers wrap mod DEPTH.
- Redirect (trap_req | flush_req sampled in cycle N):
  - Priority: trap > flush. Target is mtvec & ~3 or flush_pc & ~3, loaded into fpc.
  - Effects at edge N: FIFO cleared, in-flight kill bit set (its rdata at N+1 is discarded), and no issue in cycle N.
  - A handshake in cycle N completes normally, then the FIFO is cleared.
  - Issue at target in N+1; ifu_o_valid in N+3.
- EPC:
  - Updated only on trap_req. Capture value: head pc if FIFO non-empty (and not popped in N); else the next FIFO entry's pc, or the in-flight pc; else fpc.
  - Holds until the next trap.
- Reset mid-operation: all state clears asynchronously; any in-flight data is discarded.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- Defined: adds port ifu_o_starve_cnt (out, 32), counting cycles with ifu_i_ready=1 and ifu_o_valid=0. It saturates at 32'hFFFF_FFFF and is cleared only by reset.
- Undefined: the port and counter are absent; there is no other behavioural difference.

Test Plan:
- Reset release, ready=1, ITCM returns data = addr ^ 32'hA5A5_0000 -> first valid 2 cycles after first en with pc 0x0; then pcs 0x4, 0x8, 0xC on consecutive cycles with matching ir.
- ready=0, DEPTH=4 -> exactly 4 issues, then itcm_o_en=0 and fifo_cnt=4. Raise ready -> pcs 0x0..0xC popped in order, fetch resumes at 0x10 with no gap beyond credit.
- FIFO holds 3 entries plus 1 in-flight; flush_req with flush_pc=0x100 -> fifo_cnt=0 next cycle, no push of the stale word, itcm_o_addr=0x100 next cycle, valid 3 cycles after the flush with pc 0x100.
- trap_req and flush_req together, mtvec=0x200, flush_pc=0x100, head pc=0x40 -> redirect to 0x200, ifu_o_wbck_epc=0x40.
- trap with FIFO empty, nothing in flight, fpc=0x80 -> epc=0x80.
- fpc=0xFFFF_FFFC -> next issue address 0x0000_0000.
- With IFU_PERF_CNT_EN: ready=1 through reset release -> ifu_o_starve_cnt=2 at the first valid cycle; the count stops while valid is high.

Source files
------------

// File: rtl/ifu_pfb.sv
// ifu_pfb: instruction fetch unit that issues ITCM word fetches into a DEPTH-entry {pc, ir} prefetch FIFO feeding EXU.
// Optional macro IFU_PERF_CNT_EN adds ifu_o_starve_cnt, a saturating count of EXU-ready cycles with an empty buffer.
module ifu_pfb #(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   itcm_o_en,
  output logic [PC_W-1:0]        itcm_o_addr,
  input  logic [XLEN-1:0]        itcm_i_rdata,
  output logic                   ifu_o_valid,
  input  logic                   ifu_i_ready,
  output logic [XLEN-1:0]        ifu_o_ir,
  output logic [PC_W-1:0]        ifu_o_pc,
  input  logic                   ifu_i_flush_req,
  input  logic [PC_W-1:0]        ifu_i_flush_pc,
  input  logic                   ifu_i_trap_req,
  input  logic [PC_W-1:0]        ifu_i_mtvec,
  output logic [PC_W-1:0]        ifu_o_wbck_epc,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]            ifu_o_starve_cnt,
`endif
  output logic [$clog2(DEPTH):0] ifu_o_fifo_cnt
);

  localparam int unsigned     AW       = $clog2(DEPTH);
  localparam int unsigned     CW       = AW + 1;
  localparam logic [CW:0]     DEPTH_L  = (CW+1)'(DEPTH);
  localparam logic [PC_W-1:0] PC_INC   = PC_W'(32'd4);
  localparam logic [PC_W-1:0] PC_ALIGN = {{(PC_W-2){1'b1}}, 2'b00};

  logic [PC_W-1:0] fpc_q, fpc_d;
  logic            inflight_q, inflight_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [PC_W-1:0] pc_mem_q [DEPTH];
  logic [XLEN-1:0] ir_mem_q [DEPTH];
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PC_W-1:0] epc_q, epc_d;

  logic            pop_s;
  logic            push_s;
  logic            issue_s;
  logic            redirect_s;
  logic [PC_W-1:0] redir_tgt_s;
  logic [CW:0]     occ_s;
  logic [AW-1:0]   head_nx_s;

  assign ifu_o_valid    = (cnt_q != CW'(0));
  assign ifu_o_pc       = ifu_o_valid ? pc_mem_q[rptr_q] : {PC_W{1'b0}};
  assign ifu_o_ir       = ifu_o_valid ? ir_mem_q[rptr_q] : {XLEN{1'b0}};
  assign ifu_o_fifo_cnt = cnt_q;
  assign ifu_o_wbck_epc = epc_q;
  assign itcm_o_en      = issue_s;
  assign itcm_o_addr    = fpc_q;

  // Handshake, credit-based issue decision and redirect target selection.
  always_comb begin
    pop_s       = ifu_o_valid & ifu_i_ready;
    redirect_s  = ifu_i_trap_req | ifu_i_flush_req;
    redir_tgt_s = (ifu_i_trap_req ? ifu_i_mtvec : ifu_i_flush_pc) & PC_ALIGN;
    // In-flight word holds a slot: it lands in the FIFO next cycle.
    occ_s       = {1'b0, cnt_q} + (CW+1)'(inflight_q) - (CW+1)'(pop_s);
    issue_s     = rst_n & ~redirect_s & (occ_s < DEPTH_L);
    push_s      = inflight_q & ~redirect_s;
    head_nx_s   = rptr_q + AW'(1);
  end

  // Next-state for fetch pc, in-flight tracking, FIFO pointers and EPC.
  always_comb begin
    fpc_d         = fpc_q;
    inflight_d    = issue_s;
    inflight_pc_d = inflight_pc_q;
    rptr_d        = rptr_q;
    wptr_d        = wptr_q;
    cnt_d         = cnt_q;
    epc_d         = epc_q;
    if (redirect_s) begin
      fpc_d  = redir_tgt_s;
      rptr_d = {AW{1'b0}};
      wptr_d = {AW{1'b0}};
      cnt_d  = {CW{1'b0}};
    end else begin
      if (issue_s) begin
        fpc_d         = fpc_q + PC_INC;
        inflight_pc_d = fpc_q;
      end else begin
        inflight_pc_d = inflight_pc_q;
      end
      rptr_d = pop_s  ? head_nx_s : rptr_q;
      wptr_d = push_s ? (wptr_q + AW'(1)) : wptr_q;
      cnt_d  = cnt_q + CW'(push_s) - CW'(pop_s);
    end
    // EPC is the oldest instruction that has not been handed to EXU.
    if (ifu_i_trap_req) begin
      if (ifu_o_valid && !pop_s) begin
        epc_d = pc_mem_q[rptr_q];
      end else if (cnt_q > CW'(1)) begin
        epc_d = pc_mem_q[head_nx_s];
      end else if (inflight_q) begin
        epc_d = inflight_pc_q;
      end else begin
        epc_d = fpc_q;
      end
    end else begin
      epc_d = epc_q;
    end
  end

  // State registers and FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q         <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= {PC_W{1'b0}};
      rptr_q        <= {AW{1'b0}};
      wptr_q        <= {AW{1'b0}};
      cnt_q         <= {CW{1'b0}};
      epc_q         <= {PC_W{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i] <= {PC_W{1'b0}};
        ir_mem_q[i] <= {XLEN{1'b0}};
      end
    end else begin
      fpc_q         <= fpc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rptr_q        <= rptr_d;
      wptr_q        <= wptr_d;
      cnt_q         <= cnt_d;
      epc_q         <= epc_d;
      if (push_s) begin
        pc_mem_q[wptr_q] <= inflight_pc_q;
        ir_mem_q[wptr_q] <= itcm_i_rdata;
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] starve_q, starve_d;

  // Saturating count of cycles where EXU is ready but nothing is offered.
  always_comb begin
    if (ifu_i_ready && !ifu_o_valid && (starve_q != 32'hFFFF_FFFF)) begin
      starve_d = starve_q + 32'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 32'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign ifu_o_starve_cnt = starve_q;
`endif

endmodule
